// File: rtl/conv_encoder_controller_pkg.sv
// Shared constants and FSM state encoding for the convolution encoder controller.
package conv_encoder_controller_pkg;

  localparam int unsigned Lanes  = 14;
  localparam int unsigned DataW  = 18;
  localparam int unsigned QShift = 9;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StFill,
    StRun,
    StWait,
    StWrite,
    StClr,
    StDone
  } state_e;

endpackage

// File: rtl/conv_encoder_window_shift.sv
// 14-lane sample window: new samples enter lane 13, lane i takes lane i+1.
module conv_encoder_window_shift
  import conv_encoder_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   shift_i,
  input  logic [DataW-1:0]       din_i,
  output logic [Lanes*DataW-1:0] win_o
);

  logic [DataW-1:0] lane_q [Lanes];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Lanes; i++) lane_q[i] <= '0;
    end else if (shift_i) begin
      for (int unsigned i = 0; i < Lanes - 1; i++) lane_q[i] <= lane_q[i+1];
      lane_q[Lanes-1] <= din_i;
    end
  end

  for (genvar g = 0; g < Lanes; g++) begin : g_lane
    assign win_o[g*DataW +: DataW] = lane_q[g];
  end

endmodule

// File: rtl/conv_encoder_controller.sv
// Sequences weight load, window fill, PE-array handshake and pixel write-back
// for a 14-tap 1-D convolution over one frame.
module conv_encoder_controller
  import conv_encoder_controller_pkg::*;
#(
  parameter int unsigned IMG_LEN = 64,
  parameter int unsigned STRIDE  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [3:0]             w_addr_o,
  input  logic [DataW-1:0]       w_data_i,
  output logic [11:0]            x_addr_o,
  input  logic [DataW-1:0]       x_data_i,
  output logic [Lanes*DataW-1:0] arr_x_o,
  output logic [Lanes*DataW-1:0] arr_w_o,
  output logic                   arr_rst_o,
  output logic                   arr_start_o,
  input  logic                   arr_ready_i,
  input  logic [DataW-1:0]       arr_pixel_i,
  output logic                   y_we_o,
  output logic [11:0]            y_addr_o,
  output logic [DataW-1:0]       y_data_o
);

  localparam int unsigned NOut    = (IMG_LEN - Lanes) / STRIDE + 1;
  localparam logic [11:0] NOutW   = 12'(NOut);
  localparam logic [3:0]  LanesW  = 4'(Lanes);
  localparam logic [3:0]  StrideW = 4'(STRIDE);

  state_e           state_q;
  logic             busy_q, done_q, arr_rst_q, arr_start_q, y_we_q;
  logic [3:0]       w_cnt_q, w_addr_q, fill_cnt_q;
  logic [11:0]      x_addr_q, pix_cnt_q, y_addr_q;
  logic [DataW-1:0] y_data_q;
  logic [DataW-1:0] arr_w_q [Lanes];

  logic [3:0] fill_need;
  logic       fill_shift;

  // First window needs all 14 samples; later windows only advance by STRIDE.
  assign fill_need  = (pix_cnt_q == '0) ? LanesW : StrideW;
  // Memory data lags the address by one cycle, so capture starts on FILL cycle 1.
  assign fill_shift = (state_q == StFill) && (fill_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arr_rst_q   <= 1'b1;
      arr_start_q <= 1'b0;
      y_we_q      <= 1'b0;
      w_cnt_q     <= '0;
      w_addr_q    <= '0;
      fill_cnt_q  <= '0;
      x_addr_q    <= '0;
      pix_cnt_q   <= '0;
      y_addr_q    <= '0;
      y_data_q    <= '0;
      for (int unsigned i = 0; i < Lanes; i++) arr_w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      y_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StLoadW;
            busy_q    <= 1'b1;
            arr_rst_q <= 1'b0;
            w_cnt_q   <= '0;
            w_addr_q  <= '0;
            pix_cnt_q <= '0;
          end
        end
        StLoadW: begin
          w_cnt_q <= w_cnt_q + 4'd1;
          if (w_cnt_q != '0) arr_w_q[w_cnt_q - 4'd1] <= w_data_i;
          if (w_cnt_q < LanesW - 4'd1) w_addr_q <= w_addr_q + 4'd1;
          if (w_cnt_q == LanesW) begin
            state_q    <= StFill;
            x_addr_q   <= '0;
            fill_cnt_q <= '0;
          end
        end
        StFill: begin
          fill_cnt_q <= fill_cnt_q + 4'd1;
          if (fill_cnt_q == fill_need) begin
            state_q     <= StRun;
            arr_start_q <= 1'b1;
          end else if (fill_cnt_q + 4'd1 < fill_need) begin
            x_addr_q <= x_addr_q + 12'd1;
          end
        end
        StRun: state_q <= StWait;
        StWait: begin
          if (arr_ready_i) begin
            state_q     <= StWrite;
            arr_start_q <= 1'b0;
            y_we_q      <= 1'b1;
            y_addr_q    <= pix_cnt_q;
            y_data_q    <= arr_pixel_i;
          end
        end
        StWrite: begin
          state_q   <= StClr;
          pix_cnt_q <= pix_cnt_q + 12'd1;
          arr_rst_q <= 1'b1;
        end
        StClr: begin
          arr_rst_q <= 1'b0;
          if (pix_cnt_q == NOutW) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q    <= StFill;
            fill_cnt_q <= '0;
            x_addr_q   <= x_addr_q + 12'd1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          arr_rst_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  conv_encoder_window_shift u_window (
    .clk    (clk),
    .rst    (rst),
    .shift_i(fill_shift),
    .din_i  (x_data_i),
    .win_o  (arr_x_o)
  );

  for (genvar g = 0; g < Lanes; g++) begin : g_wlane
    assign arr_w_o[g*DataW +: DataW] = arr_w_q[g];
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign w_addr_o    = w_addr_q;
  assign x_addr_o    = x_addr_q;
  assign arr_rst_o   = arr_rst_q;
  assign arr_start_o = arr_start_q;
  assign y_we_o      = y_we_q;
  assign y_addr_o    = y_addr_q;
  assign y_data_o    = y_data_q;

endmodule

// File: tb/tb_conv_encoder_controller.sv
// Bench: three controller configurations driven against memory and PE-array models.
module tb_conv_encoder_controller;
  import conv_encoder_controller_pkg::*;

  localparam int NI = 3;

  logic clk;
  logic rst [NI];
  logic start [NI];
  logic busy [NI];
  logic done [NI];
  logic [3:0] w_addr [NI];
  logic [17:0] w_data [NI];
  logic [11:0] x_addr [NI];
  logic [17:0] x_data [NI];
  logic [251:0] arr_x [NI];
  logic [251:0] arr_w [NI];
  logic arr_rst [NI];
  logic arr_start [NI];
  logic arr_ready [NI];
  logic [17:0] arr_pixel [NI];
  logic y_we [NI];
  logic [11:0] y_addr [NI];
  logic [17:0] y_data [NI];

  logic signed [17:0] wmem [NI][14];
  logic signed [17:0] xmem [NI][32];
  int rdy_cnt [NI];
  int rdy_delay [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    conv_encoder_controller #(
      .IMG_LEN(g == 0 ? 16 : (g == 1 ? 20 : 14)),
      .STRIDE (g == 1 ? 3 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .start_i    (start[g]),
      .busy_o     (busy[g]),
      .done_o     (done[g]),
      .w_addr_o   (w_addr[g]),
      .w_data_i   (w_data[g]),
      .x_addr_o   (x_addr[g]),
      .x_data_i   (x_data[g]),
      .arr_x_o    (arr_x[g]),
      .arr_w_o    (arr_w[g]),
      .arr_rst_o  (arr_rst[g]),
      .arr_start_o(arr_start[g]),
      .arr_ready_i(arr_ready[g]),
      .arr_pixel_i(arr_pixel[g]),
      .y_we_o     (y_we[g]),
      .y_addr_o   (y_addr[g]),
      .y_data_o   (y_data[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int img_len_of(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 20 : 14);
  endfunction

  function automatic int stride_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic int nout_of(input int k);
    return (img_len_of(k) - 14) / stride_of(k) + 1;
  endfunction

  // Reference: pixel n is the dot product of samples n*S..n*S+13 with the weights.
  function automatic logic [17:0] exp_pix(input int k, input int n);
    longint acc = 0;
    for (int i = 0; i < 14; i++)
      acc += longint'(xmem[k][n * stride_of(k) + i]) * longint'(wmem[k][i]);
    acc = acc >>> QShift;
    return acc[17:0];
  endfunction

  function automatic logic [17:0] pe_sum(input logic [251:0] xv, input logic [251:0] wv);
    longint acc = 0;
    for (int i = 0; i < 14; i++)
      acc += longint'($signed(xv[i*18 +: 18])) * longint'($signed(wv[i*18 +: 18]));
    acc = acc >>> QShift;
    return acc[17:0];
  endfunction

  // Synchronous-read memories and the PE array model.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      w_data[k] <= wmem[k][w_addr[k]];
      x_data[k] <= xmem[k][x_addr[k][4:0]];
      if (arr_rst[k]) begin
        arr_ready[k] <= 1'b0;
        rdy_cnt[k]   <= 0;
      end else if (arr_start[k] && !arr_ready[k]) begin
        rdy_cnt[k] <= rdy_cnt[k] + 1;
        if (rdy_cnt[k] + 1 >= rdy_delay[k]) begin
          arr_ready[k] <= 1'b1;
          arr_pixel[k] <= pe_sum(arr_x[k], arr_w[k]);
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // mode 0: plain frame, 1: start pulsed in second WAIT, 2: rst in second WAIT.
  task automatic run_frame(input int k, input int mode);
    int nout = nout_of(k);
    int nwr = 0, ndone = 0, maxx = 0, stall = 0, cyc = 0, post = 0;
    int starts = 0, since_rise = 0, late_we = 0, late_done = 0;
    int budget = 600 + nout * (rdy_delay[k] + 40);
    bit fin = 0, pulsed = 0, prev_start = 0, aborted = 0;
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    check_eq($sformatf("k%0d_load_busy", k), 32'(busy[k]), 32'd1);
    check_eq($sformatf("k%0d_load_arr_rst", k), 32'(arr_rst[k]), 32'd0);
    check_eq($sformatf("k%0d_load_w_addr", k), 32'(w_addr[k]), 32'd0);
    while (!fin) begin
      @(negedge clk);
      start[k] = 1'b0;
      cyc++;
      if (int'(x_addr[k]) > maxx) maxx = int'(x_addr[k]);
      if (arr_start[k] && !arr_ready[k]) stall++;
      if (arr_start[k] && !prev_start) begin
        starts++;
        since_rise = 0;
      end else if (arr_start[k]) begin
        since_rise++;
      end
      prev_start = arr_start[k];
      if (y_we[k]) begin
        check_eq($sformatf("k%0d_y_addr%0d", k, nwr), 32'(y_addr[k]), 32'(nwr));
        check_eq($sformatf("k%0d_y_data%0d", k, nwr), 32'(y_data[k]), 32'(exp_pix(k, nwr)));
        nwr++;
      end
      if (done[k]) ndone++;
      if (ndone > 0) post++;
      if (mode == 1 && !pulsed && starts == 2 && since_rise == 2) begin
        start[k] = 1'b1;
        pulsed = 1;
      end
      if (mode == 2 && starts == 2 && since_rise == 2) begin
        rst[k] = 1'b1;
        @(negedge clk);
        check_eq($sformatf("k%0d_abort_arr_rst", k), 32'(arr_rst[k]), 32'd1);
        check_eq($sformatf("k%0d_abort_busy", k), 32'(busy[k]), 32'd0);
        check_eq($sformatf("k%0d_abort_start", k), 32'(arr_start[k]), 32'd0);
        check_eq($sformatf("k%0d_abort_writes", k), 32'(nwr), 32'd1);
        rst[k] = 1'b0;
        repeat (40) begin
          @(negedge clk);
          if (y_we[k]) late_we++;
          if (done[k]) late_done++;
        end
        check_eq($sformatf("k%0d_abort_late_we", k), 32'(late_we), 32'd0);
        check_eq($sformatf("k%0d_abort_late_done", k), 32'(late_done), 32'd0);
        aborted = 1;
        fin = 1;
      end
      if (post == 3 || cyc > budget) fin = 1;
    end
    if (!aborted) begin
      check_eq($sformatf("k%0d_writes", k), 32'(nwr), 32'(nout));
      check_eq($sformatf("k%0d_done_pulses", k), 32'(ndone), 32'd1);
      check_eq($sformatf("k%0d_stall", k), 32'(stall), 32'(nout * rdy_delay[k]));
      check_eq($sformatf("k%0d_max_x_addr", k), 32'(maxx),
               32'((nout - 1) * stride_of(k) + 13));
      check_eq($sformatf("k%0d_idle_busy", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("k%0d_idle_arr_rst", k), 32'(arr_rst[k]), 32'd1);
    end
  endtask

  initial begin
    int v;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      start[k] = 1'b0;
      rdy_delay[k] = 5;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("k%0d_rst_busy", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("k%0d_rst_done", k), 32'(done[k]), 32'd0);
      check_eq($sformatf("k%0d_rst_y_we", k), 32'(y_we[k]), 32'd0);
      check_eq($sformatf("k%0d_rst_arr_start", k), 32'(arr_start[k]), 32'd0);
      check_eq($sformatf("k%0d_rst_arr_rst", k), 32'(arr_rst[k]), 32'd1);
      check_eq($sformatf("k%0d_rst_addrs", k),
               32'({w_addr[k], x_addr[k], y_addr[k]}), 32'd0);
      check_eq($sformatf("k%0d_rst_y_data", k), 32'(y_data[k]), 32'd0);
      check_eq($sformatf("k%0d_rst_arr_nz", k), 32'(|{arr_x[k], arr_w[k]}), 32'd0);
      rst[k] = 1'b0;
    end

    // All-512 weights and samples.
    for (int i = 0; i < 14; i++) wmem[0][i] = 18'sd512;
    for (int i = 0; i < 32; i++) xmem[0][i] = 18'sd512;
    run_frame(0, 0);
    run_frame(0, 1);
    run_frame(0, 2);
    run_frame(0, 0);
    rdy_delay[0] = 200;
    run_frame(0, 0);
    rdy_delay[0] = 5;

    // Ramp samples with a single tap on lane 0, stride 3.
    for (int i = 0; i < 14; i++) wmem[1][i] = (i == 0) ? 18'sd512 : 18'sd0;
    for (int i = 0; i < 32; i++) xmem[1][i] = 18'(i * 512);
    run_frame(1, 0);

    // Minimum frame length: one window.
    for (int i = 0; i < 14; i++) wmem[2][i] = 18'sd512;
    for (int i = 0; i < 32; i++) xmem[2][i] = 18'sd512;
    run_frame(2, 0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NI; k++) begin
        for (int i = 0; i < 14; i++) begin
          v = int'($urandom_range(4094, 0)) - 2047;
          wmem[k][i] = 18'(v);
        end
        for (int i = 0; i < 32; i++) begin
          v = int'($urandom_range(4094, 0)) - 2047;
          xmem[k][i] = 18'(v);
        end
        rdy_delay[k] = int'($urandom_range(12, 1));
        run_frame(k, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder_controller.md
CONV_ENCODER_CONTROLLER -- requirements
Module: conv_encoder_controller

Interface
REQ-001 Parameter IMG_LEN, default 64: input samples per frame; legal range 14..4095.
REQ-002 Parameter STRIDE, default 1: window advance per output pixel; legal range 1..14.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  single-cycle frame request; honoured only in IDLE.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle pulse after the last pixel is written.
REQ-008 w_addr  out  4  weight memory read address, 0..13.
REQ-009 w_data  in  18  signed Q9 weight; valid 1 cycle after w_addr.
REQ-010 x_addr  out  12  input memory read address.
REQ-011 x_data  in  18  signed Q9 sample; valid 1 cycle after x_addr.
REQ-012 arr_x  out  252  14 packed window samples; lane i in bits [18i+17:18i].
REQ-013 arr_w  out  252  14 packed weights, same lane packing as arr_x.
REQ-014 arr_rst  out  1  registered synchronous reset for the PE array.
REQ-015 arr_start  out  1  registered start to the PE array.
REQ-016 arr_ready  in  1  array result valid; sticky until arr_rst.
REQ-017 arr_pixel  in  18  signed array result.
REQ-018 y_we  out  1  output write strobe.
REQ-019 y_addr  out  12  output pixel index.
REQ-020 y_data  out  18  output pixel, equal to arr_pixel.

Function
REQ-021 The controller SHALL use states IDLE, LOAD_W, FILL, RUN, WAIT, WRITE, CLR, DONE.
REQ-022 IDLE->LOAD_W on start; weight counter SHALL be cleared.
REQ-023 LOAD_W SHALL issue w_addr 0..13 on consecutive cycles and capture each returned word into arr_w lane k, where k is the address; total duration 15 cycles.
REQ-024 FILL SHALL read STRIDE new samples (14 for the first pixel) at ascending x_addr and shift each into lane 13, with lane i taking lane i+1.
REQ-025 After the final FILL capture the FSM SHALL enter RUN; RUN SHALL assert arr_start for 1 cycle and then go to WAIT.
REQ-026 arr_start SHALL stay high through WAIT and fall on the cycle WRITE is entered.
REQ-027 WAIT SHALL hold until arr_ready=1, with no timeout.
REQ-028 WRITE SHALL last 1 cycle, with y_we=1, y_addr equal to the pixel counter, and y_data equal to arr_pixel; the pixel counter SHALL then increment.
REQ-029 CLR SHALL assert arr_rst for exactly 1 cycle, then go to FILL, or to DONE if pixel count equals N_OUT.
REQ-030 N_OUT SHALL equal floor((IMG_LEN-14)/STRIDE)+1, computed at elaboration.
REQ-031 Output pixel n SHALL use samples n*STRIDE..n*STRIDE+13; trailing samples that do not fill a window SHALL be ignored.
REQ-032 DONE SHALL pulse done for 1 cycle and return to IDLE.
REQ-033 start asserted while busy=1 SHALL be ignored.
REQ-034 x_addr SHALL never exceed IMG_LEN-1; the sample and pixel counters SHALL not wrap within a frame.
REQ-035 arr_x and arr_w SHALL be stable from RUN through WRITE.
REQ-036 Unused address outputs SHALL hold their last value; y_we SHALL be 0 outside WRITE.

Reset
REQ-037 On rst, state SHALL become IDLE and busy, done, y_we and arr_start SHALL be 0.
REQ-038 On rst, arr_rst SHALL be 1 and SHALL remain 1 in IDLE; it SHALL deassert on the first cycle of LOAD_W.
REQ-039 On rst, all addresses, counters, arr_x, arr_w and y_data SHALL be 0.
REQ-040 rst asserted mid-frame SHALL abort the frame immediately, with no further y_we and no done pulse.

Structure
REQ-041 The shared package SHALL hold: lane count 14, data width 18, Q-shift 9, and the FSM state enumeration.
REQ-042 A single sub-module, conv_encoder_window_shift, SHALL implement the 14-lane shift window used for arr_x.
REQ-043 The PE array SHALL be instantiated by the parent, not inside this block.

Verification
REQ-044 The bench SHALL model the array as: arr_pixel = sum(x_i*w_i)>>>9, arr_ready asserted 5 cycles after arr_start rises, sticky until arr_rst.
REQ-045 Scenario 1: IMG_LEN=16, STRIDE=1, all weights 512, all samples 512 -> 3 writes at y_addr 0,1,2, each with data 7168, then done.
REQ-046 Scenario 2: IMG_LEN=20, STRIDE=3, x[n]=n*512, w0=512 and other weights 0 -> 3 writes with data 0, 1536, 3072.
REQ-047 Scenario 3: start pulsed during WAIT of Scenario 1 -> identical output sequence and exactly one done pulse.
REQ-048 Scenario 4: rst asserted during the second WAIT -> no further y_we, arr_rst=1 on the next cycle, and a fresh start reproduces Scenario 1.
REQ-049 Scenario 5: IMG_LEN=14 -> exactly 1 write, and the highest x_addr issued is 13.
REQ-050 Scenario 6: array ready delay extended to 200 cycles -> controller stalls in WAIT with arr_start high and produces the same data as Scenario 1.
